div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 28 ++
 rtl/div_unit_step.sv | 27 ++
 rtl/div_unit.sv | 185 ++++++++++++++++++
 tb/tb_div_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared operation codes, FSM state encoding and decode helpers for div_unit.
package div_unit_pkg;

    localparam logic [4:0] ALU_DIV  = 5'h0c;
    localparam logic [4:0] ALU_DIVU = 5'h0d;
    localparam logic [4:0] ALU_REM  = 5'h0e;
    localparam logic [4:0] ALU_REMU = 5'h0f;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [4:0] code);
        return (code == ALU_DIV) || (code == ALU_DIVU) ||
               (code == ALU_REM) || (code == ALU_REMU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] code);
        return (code == ALU_DIV) || (code == ALU_REM);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] code);
        return (code == ALU_REM) || (code == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// div_step: one combinational radix-2 restoring division step on unsigned magnitudes.
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    // Shift the next dividend bit into the partial remainder and subtract the divisor if it fits.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        fits    = (shifted >= {1'b0, divisor});
        rem_out = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative signed/unsigned divider with valid/ready handshakes, flush and sync reset.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC and respond in one cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       alucode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    div_state_e       state_q;
    div_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] result_q;

    logic             accept;
    logic             consume;
    logic             last_iter;
    logic             op_signed;
    logic             x_neg;
    logic             y_neg;
    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag;
    logic             y_zero;
    logic             overflow;
    logic             special;
    logic [WIDTH-1:0] special_result;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] final_result;

    assign accept    = req_valid && (state_q == IDLE) && !flush;
    assign consume   = (state_q == DONE) && resp_ready;
    assign last_iter = (cnt_q == LAST_CNT);

    assign op_signed = is_signed_op(alucode);
    assign x_neg     = op_signed && x[WIDTH-1];
    assign y_neg     = op_signed && y[WIDTH-1];
    assign x_mag     = x_neg ? (~x + 1'b1) : x;
    assign y_mag     = y_neg ? (~y + 1'b1) : y;
    assign y_zero    = (y == ZERO);
    assign overflow  = op_signed && (x == MIN_NEG) && (y == ALL_ONES);
    assign special   = is_div_op(alucode) && (y_zero || overflow);

    assign special_result = y_zero ? (is_rem_op(alucode) ? x : ALL_ONES)
                                   : (is_rem_op(alucode) ? ZERO : x);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    assign quo_fix      = div_zero_q ? ALL_ONES : (neg_quo_q ? (~step_quo + 1'b1) : step_quo);
    assign rem_fix      = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
    assign final_result = is_rem_op(op_q) ? rem_fix : quo_fix;

    // State register; reset overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; flush kills any in-flight or pending result.
    always_comb begin
        state_d    = state_q;
        req_ready  = (state_q == IDLE) && !flush;
        resp_valid = (state_q == DONE);
        busy       = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_div_op(alucode) || (EARLY_OUT && special)) begin
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (consume) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Operand capture at accept, one restoring step per CALC cycle, and result capture on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            op_q       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q       <= alucode;
                        cnt_q      <= '0;
                        rem_q      <= '0;
                        quo_q      <= x_mag;
                        dvs_q      <= y_mag;
                        neg_quo_q  <= x_neg ^ y_neg;
                        neg_rem_q  <= x_neg;
                        div_zero_q <= y_zero;
                        if (!is_div_op(alucode)) begin
                            result_q <= ZERO;
                        end else if (EARLY_OUT && special) begin
                            result_q <= special_result;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        rem_q <= step_rem;
                        quo_q <= step_quo;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_iter) begin
                            result_q <= final_result;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit (WIDTH=32) with hand-computed results.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int WIDTH = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif
    localparam int NORMAL_LAT = 33;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       alucode;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    int checks;
    int errors;

    div_unit #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .alucode    (alucode),
        .x          (x),
        .y          (y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] code, input logic [31:0] xv, input logic [31:0] yv);
        @(negedge clk);
        req_valid = 1'b1;
        alucode   = code;
        x         = xv;
        y         = yv;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitResp(output int lat);
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic consumeResp(input string tag);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_idle_rv"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic runOp(input string tag, input logic [4:0] code, input logic [31:0] xv,
                         input logic [31:0] yv, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        applyStimulus(code, xv, yv);
        waitResp(lat);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_res"}, result, exp_res);
        consumeResp(tag);
    endtask

    task automatic watchNoResp(input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        checkOutput({tag, "_no_resp"}, 32'(seen), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        alucode    = 5'h00;
        x          = '0;
        y          = '0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_result", result, 32'd0);

        $display("[TB] basic signed/unsigned division");
        runOp("div_100_7", ALU_DIV, 32'd100, 32'd7, 32'd14, NORMAL_LAT);
        runOp("rem_100_7", ALU_REM, 32'd100, 32'd7, 32'd2, NORMAL_LAT);
        runOp("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORMAL_LAT);
        runOp("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORMAL_LAT);
        runOp("divu_max_2", ALU_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, NORMAL_LAT);
        runOp("div_7_m2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, NORMAL_LAT);

        $display("[TB] divide by zero and overflow");
        runOp("divu_5_0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
        runOp("remu_5_0", ALU_REMU, 32'd5, 32'd0, 32'd5, SPECIAL_LAT);
        runOp("div_m7_0", ALU_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
        runOp("rem_m7_0", ALU_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SPECIAL_LAT);
        runOp("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);
        runOp("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_LAT);

        $display("[TB] non-divide opcode");
        runOp("nondiv", 5'h00, 32'd123, 32'd4, 32'd0, 1);

        $display("[TB] backpressure in DONE");
        applyStimulus(ALU_DIV, 32'd100, 32'd7);
        waitResp(lat);
        checkOutput("bp_lat", 32'(lat), 32'(NORMAL_LAT));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_result", result, 32'd14);
            checkOutput("bp_resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
            checkOutput("bp_busy", 32'(busy), 32'd1);
        end
        consumeResp("bp");

        $display("[TB] flush during CALC");
        applyStimulus(ALU_DIV, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        checkOutput("flush_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_req_ready", 32'(req_ready), 32'd1);
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_resp_valid", 32'(resp_valid), 32'd0);
        watchNoResp("flush");

        $display("[TB] reset during CALC");
        applyStimulus(ALU_DIV, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        watchNoResp("rst");

        $display("[TB] recovery after reset");
        runOp("rec_divu", ALU_DIVU, 32'd1000, 32'd10, 32'd100, NORMAL_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
